// File: rtl/shift_timer_pkg.sv
// Shared state encoding and default shift counts for the shift phase timer.
package shift_timer_pkg;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_MID  = 2'd1;
    localparam logic [1:0] PH_REM  = 2'd2;
    localparam logic [1:0] PH_DONE = 2'd3;

    localparam int DEF_MID_SHIFTS = 8;
    localparam int DEF_REM_SHIFTS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = PH_IDLE,
        ST_MID  = PH_MID,
        ST_REM  = PH_REM,
        ST_DONE = PH_DONE
    } state_t;

endpackage

// File: rtl/shift_phase_counter.sv
// Shift index counter with synchronous clear, enable and terminal compare.
module shift_phase_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             at_term
);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_term = (cnt == term);

endmodule

// File: rtl/shift_phase_timer.sv
// Two-phase (midstate / remaining-data) shift sequencer.
// Optional macro TIMER_STALL_EN makes the stall input freeze shifting.
module shift_phase_timer
    import shift_timer_pkg::*;
#(
    parameter int CNT_W      = 6,
    parameter int MID_SHIFTS = DEF_MID_SHIFTS,
    parameter int REM_SHIFTS = DEF_REM_SHIFTS
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             flush,
    input  logic             ack,
    input  logic             stall,
    output logic             shift_en,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] cnt,
    output logic             mid_done,
    output logic             rem_done,
    output logic             busy
);

    localparam int MAX_SHIFTS =
        (MID_SHIFTS > REM_SHIFTS) ? MID_SHIFTS : REM_SHIFTS;
    localparam logic [CNT_W-1:0] MID_LAST = CNT_W'(MID_SHIFTS - 1);
    localparam logic [CNT_W-1:0] REM_LAST = CNT_W'(REM_SHIFTS - 1);

    if (MID_SHIFTS < 1 || REM_SHIFTS < 1 ||
        (2 ** CNT_W) < MAX_SHIFTS) begin : g_bad_params
        $error("shift_phase_timer: illegal shift count parameters");
    end

    state_t           state;
    state_t           state_nxt;
    logic             hold;
    logic             clr;
    logic             at_term;
    logic             mid_nxt;
    logic             rem_nxt;
    logic [CNT_W-1:0] term;

`ifdef TIMER_STALL_EN
    assign hold = stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign hold = 1'b0;
`endif

    assign busy     = (state == ST_MID) || (state == ST_REM);
    assign shift_en = busy && !hold;
    assign phase    = state;
    assign term     = (state == ST_MID) ? MID_LAST : REM_LAST;

    shift_phase_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (clr),
        .en     (shift_en),
        .term   (term),
        .cnt    (cnt),
        .at_term(at_term)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            mid_done <= 1'b0;
            rem_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            mid_done <= mid_nxt;
            rem_done <= rem_nxt;
        end
    end

    // flush beats start, start beats the phase-end transition
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        mid_nxt   = 1'b0;
        rem_nxt   = 1'b0;
        if (flush) begin
            state_nxt = ST_IDLE;
            clr       = 1'b1;
        end else if (start) begin
            state_nxt = ST_MID;
            clr       = 1'b1;
        end else begin
            case (state)
                ST_MID: begin
                    if (shift_en && at_term) begin
                        state_nxt = ST_REM;
                        clr       = 1'b1;
                        mid_nxt   = 1'b1;
                    end
                end
                ST_REM: begin
                    if (shift_en && at_term) begin
                        state_nxt = ST_DONE;
                        clr       = 1'b1;
                        rem_nxt   = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state_nxt = ST_IDLE;
                        clr       = 1'b1;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

endmodule

// File: doc/shift_phase_timer.md
SHIFT_PHASE_TIMER -- requirements
Module: shift_phase_timer

Interface
REQ-001 Parameter CNT_W, default 6, shift-counter width in bits.
REQ-002 Parameter MID_SHIFTS, default 8, shifts in the midstate phase.
REQ-003 Parameter REM_SHIFTS, default 16, shifts in the remaining-data phase.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 n_rst  input  1  reset, synchronous and active-low.
REQ-006 start  input  1  begin or restart a shift sequence.
REQ-007 flush  input  1  abandon any sequence and return to idle.
REQ-008 ack  input  1  release the DONE state.
REQ-009 stall  input  1  freeze counting for this cycle; functional only under TIMER_STALL_EN.
REQ-010 shift_en  output  1  high on every cycle in which a shift occurs.
REQ-011 phase  output  2  encoding: 0 IDLE, 1 MID, 2 REM, 3 DONE.
REQ-012 cnt  output  CNT_W  shift index within the current phase.
REQ-013 mid_done  output  1  one-cycle pulse: midstate shifts complete.
REQ-014 rem_done  output  1  one-cycle pulse: remaining shifts complete.
REQ-015 busy  output  1  high while phase is MID or REM.

Function
REQ-016 The FSM SHALL have four states, IDLE, MID, REM and DONE, with phase as a direct registered encoding of the state.
REQ-017 IDLE with start=1 SHALL move to MID with cnt=0 on the next cycle.
REQ-018 A shift SHALL occur in MID or REM when the stall term is 0; shift_en SHALL be combinational from state and stall.
REQ-019 Each shift SHALL increment cnt by 1; cnt SHALL hold when no shift occurs.
REQ-020 A shift in MID with cnt==MID_SHIFTS-1 SHALL move to REM, clear cnt to 0, and assert mid_done on the following cycle only.
REQ-021 A shift in REM with cnt==REM_SHIFTS-1 SHALL move to DONE, clear cnt to 0, and assert rem_done on the following cycle only.
REQ-022 DONE SHALL hold until ack=1, then move to IDLE; ack outside DONE SHALL be ignored.
REQ-023 start=1 in MID, REM or DONE SHALL restart the sequence: MID with cnt=0 next cycle, and no done pulse.
REQ-024 flush=1 in any state SHALL force IDLE with cnt=0 next cycle and suppress any pending done pulse.
REQ-025 flush SHALL take priority over start, and start SHALL take priority over the phase-end transition in the same cycle.
REQ-026 cnt SHALL never exceed max(MID_SHIFTS,REM_SHIFTS)-1, so no wrap-around occurs.
REQ-027 Latency from start to the mid_done pulse SHALL be MID_SHIFTS+1 cycles with no stalls; from start to rem_done it SHALL be MID_SHIFTS+REM_SHIFTS+1 cycles.
REQ-028 Elaboration SHALL fail if MID_SHIFTS<1, REM_SHIFTS<1, or 2**CNT_W < max(MID_SHIFTS,REM_SHIFTS).

Reset
REQ-029 n_rst=0 at a clock edge SHALL force IDLE, cnt=0, mid_done=0, rem_done=0 and busy=0, with priority over every other input.
REQ-030 A reset in mid-sequence SHALL discard the sequence; no done pulse SHALL follow reset release.

Configuration
REQ-031 With macro TIMER_STALL_EN defined, stall=1 SHALL suppress shift_en and freeze cnt and state (flush, start and n_rst still act).
REQ-032 Without TIMER_STALL_EN, the stall port SHALL remain present but be ignored, and every MID/REM cycle SHALL shift.

Structure
REQ-033 Package shift_timer_pkg SHALL hold the state enum, the phase encoding constants, and the default MID_SHIFTS/REM_SHIFTS values.
REQ-034 The counter SHALL be the sub-module shift_phase_counter (parameter CNT_W; sync clear, enable, terminal-value compare output).

Verification
REQ-035 Default parameters, start pulse at cycle 0, no stall -> mid_done high at cycle 9 only; rem_done high at cycle 25 only; phase=3 until ack.
REQ-036 TIMER_STALL_EN defined, stall high for 3 cycles during MID at cnt=4 -> cnt holds 4 and shift_en=0 for those cycles; mid_done delayed to cycle 12.
REQ-037 start reasserted in REM at cnt=10 -> phase=1 and cnt=0 next cycle; no rem_done for the aborted sequence.
REQ-038 flush and start together in REM at cnt=15 -> IDLE, cnt=0, and no rem_done pulse.
REQ-039 n_rst low for 1 cycle in MID at cnt=7 -> IDLE, all outputs 0, and no mid_done afterwards.
REQ-040 MID_SHIFTS=1, REM_SHIFTS=1, CNT_W=1 -> mid_done at cycle 2 and rem_done at cycle 3 after start; ack in IDLE has no effect.
